// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - 3-stage signed int32 to IEEE-754 single converter, round-to-nearest-even
module itof_pipe #(
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  if (STAGES != 3) begin : g_bad_stages
    $error("itof_pipe: only STAGES=3 is supported");
  end

  logic        w_advance;
  logic [31:0] w_mag;
  logic [4:0]  w_lz;
  logic [31:0] w_norm;
  logic [22:0] w_m;
  logic        w_g;
  logic        w_st;
  logic        w_l;
  logic        w_rnd;
  logic [23:0] w_sum;
  logic        w_c;
  logic [7:0]  w_exp;
  logic [31:0] w_res;
  logic        w_inx;

  logic        r_v1;
  logic        r_s1;
  logic        r_z1;
  logic [31:0] r_mag1;
  logic        r_v2;
  logic        r_s2;
  logic        r_z2;
  logic [4:0]  r_lz2;
  logic [31:0] r_norm2;
  logic        r_v3;
  logic [31:0] r_data3;
  logic        r_inx3;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign w_advance   = !r_v3 | out_ready;
  assign in_ready    = w_advance;
  assign out_valid   = r_v3;
  assign out_data    = r_data3;
  assign out_inexact = r_inx3;

  assign w_mag = in_data[31] ? (~in_data + 32'd1) : in_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1   <= 1'b0;
      r_s1   <= 1'b0;
      r_z1   <= 1'b0;
      r_mag1 <= 32'd0;
    end else if (w_advance) begin
      r_v1   <= in_valid;
      r_s1   <= in_data[31];
      r_z1   <= (in_data == 32'd0);
      r_mag1 <= w_mag;
    end
  end

  always_comb begin
    logic found;
    w_lz  = 5'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && r_mag1[i]) begin
        w_lz  = 5'(31 - i);
        found = 1'b1;
      end
    end
  end

  assign w_norm = r_mag1 << w_lz;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v2    <= 1'b0;
      r_s2    <= 1'b0;
      r_z2    <= 1'b0;
      r_lz2   <= 5'd0;
      r_norm2 <= 32'd0;
    end else if (w_advance) begin
      r_v2    <= r_v1;
      r_s2    <= r_s1;
      r_z2    <= r_z1;
      r_lz2   <= w_lz;
      r_norm2 <= w_norm;
    end
  end

  assign w_m   = r_norm2[30:8];
  assign w_g   = r_norm2[7];
  assign w_st  = |r_norm2[6:0];
  assign w_l   = r_norm2[8];
  assign w_rnd = w_g & (w_st | w_l);
  assign w_sum = {1'b0, w_m} + {23'd0, w_rnd};
  assign w_c   = w_sum[23];
  // A mantissa carry-out means the value rounded up to the next power of two.
  assign w_exp = 8'd158 - {3'd0, r_lz2} + {7'd0, w_c};
  assign w_res = r_z2 ? 32'h0 : {r_s2, w_exp, (w_c ? 23'd0 : w_sum[22:0])};
  assign w_inx = w_g | w_st;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v3    <= 1'b0;
      r_data3 <= 32'd0;
      r_inx3  <= 1'b0;
    end else if (w_advance) begin
      r_v3    <= r_v2;
      r_data3 <= w_res;
      r_inx3  <= w_inx;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - randomized and directed bench for itof_pipe against an arithmetic model
module tb_itof_pipe;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  itof_pipe #(.STAGES(3)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inexact(out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [32:0] expq[$];
  logic        s_ov = 1'b0;
  logic        hold_pend = 1'b0;
  logic [32:0] held = 33'd0;

  // Exact integer rounding: find the leading power of two, split off the
  // bits below single precision and round the quotient to nearest even.
  function automatic logic [32:0] ref_conv(input logic [31:0] x);
    longint a, q, r, half;
    int     p, sh;
    logic   s, inx;
    if (x == 32'd0) return 33'd0;
    s = x[31];
    a = longint'({32'd0, x});
    if (s) a = 64'h1_0000_0000 - a;
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    inx = 1'b0;
    if (p > 23) begin
      sh   = p - 23;
      q    = a >> sh;
      r    = a - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      inx = (r != 0);
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end else begin
      q = a << (23 - p);
    end
    return {inx, s, 8'(p + 127), q[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                       input logic [32:0] e, output logic acc);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    s_ov = out_valid;
    chk("in_ready", {32'd0, in_ready}, {32'd0, (!out_valid || out_ready)});
    if (hold_pend && out_valid) chk("stall_hold", {out_inexact, out_data}, held);
    hold_pend = out_valid && !out_ready;
    held      = {out_inexact, out_data};
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        total++;
        assert (expq.size() != 0) else begin
          bad++;
          $error("FAIL spurious_out: observed output %h with nothing pending, expected none", out_data);
        end
      end else begin
        chk("result", {out_inexact, out_data}, expq.pop_front());
      end
    end
    acc = v && in_ready;
    if (acc) expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic send_dir(input logic [31:0] d, input logic [32:0] e);
    logic acc;
    cycle(1'b1, d, 1'b1, e, acc);
    chk("dir_accept", {32'd0, acc}, 33'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 40 && expq.size() > 0; n++) cycle(1'b0, 32'd0, 1'b1, 33'd0, acc);
    chk("drain_empty", 33'(expq.size()), 33'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] d;
    logic [31:0] bp_vals[5];
    int          sent, cyc, lat, sh;
    logic        v, ordy;

    rstn = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_out_data", {1'b0, out_data}, 33'd0);
    chk("rst_out_inexact", {32'd0, out_inexact}, 33'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Basic and rounding vectors with spec-given results.
    send_dir(32'd0,        {1'b0, 32'h0000_0000});
    send_dir(32'd1,        {1'b0, 32'h3F80_0000});
    send_dir(32'hFFFF_FFFF,{1'b0, 32'hBF80_0000});
    send_dir(32'h8000_0000,{1'b0, 32'hCF00_0000});
    send_dir(32'd16777217, {1'b1, 32'h4B80_0000});
    send_dir(32'd16777219, {1'b1, 32'h4B80_0002});
    send_dir(32'd16777221, {1'b1, 32'h4B80_0002});
    send_dir(32'h7FFF_FFFF,{1'b1, 32'h4F00_0000});
    drain();

    // Bubbles: valid pattern 1,0,1,0 must reappear three cycles later.
    for (int i = 0; i < 8; i++) begin
      v = (i < 4) && (i % 2 == 0);
      d = 32'(i * 1000 + 7);
      cycle(v, d, 1'b1, ref_conv(d), acc);
      chk("bubble_ov", {32'd0, s_ov}, {32'd0, (i == 3 || i == 5)});
    end
    drain();

    // Backpressure: out_ready low for four cycles starting at cycle 2.
    bp_vals[0] = 32'd12345; bp_vals[1] = 32'hFFFF_0001; bp_vals[2] = 32'd33554435;
    bp_vals[3] = 32'd5;     bp_vals[4] = 32'h8000_0001;
    sent = 0;
    cyc  = 0;
    while (sent < 5 && cyc < 50) begin
      ordy = !(cyc >= 2 && cyc < 6);
      cycle(1'b1, bp_vals[sent], ordy, ref_conv(bp_vals[sent]), acc);
      if (acc) sent++;
      cyc++;
    end
    chk("bp_sent", 33'(sent), 33'd5);
    chk("bp_stall_cycles", 33'(cyc), 33'd8);
    drain();

    // Reset mid-stream with three items in flight.
    send_dir(32'd100, ref_conv(32'd100));
    send_dir(32'd200, ref_conv(32'd200));
    send_dir(32'd300, ref_conv(32'd300));
    chk("inflight_valid", {32'd0, out_valid}, 33'd1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("midrst_out_data", {1'b0, out_data}, 33'd0);
    chk("midrst_out_inexact", {32'd0, out_inexact}, 33'd0);
    expq.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    send_dir(32'd2, {1'b0, 32'h4000_0000});
    lat = 0;
    do begin
      cycle(1'b0, 32'd0, 1'b1, 33'd0, acc);
      lat++;
    end while (!s_ov && lat < 8);
    chk("latency", 33'(lat), 33'd3);
    drain();

    // Powers of two and their neighbours, both signs.
    for (int k = 0; k < 32; k++) begin
      for (int dl = -1; dl <= 1; dl++) begin
        d = (32'd1 << k) + 32'(dl);
        send_dir(d, ref_conv(d));
        send_dir(-d, ref_conv(-d));
      end
    end
    drain();

    // Random sweep with random gaps and random backpressure.
    for (int n = 0; n < 20000; n++) begin
      sh = $urandom_range(0, 31);
      case ($urandom_range(0, 2))
        0: d = $urandom;
        1: d = $urandom >> sh;
        default: d = -($urandom >> sh);
      endcase
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 7) != 0);
      cycle(v, d, ordy, ref_conv(d), acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
